aes_dec_iter: RTL

Iterative AES-128 decryption core. Accepts one 128-bit ciphertext block with its round-10 key and runs the ten inverse rounds, one per clock. It reverses the key schedule on the fly, so only the final encryption round key is required. It sits on the decrypt path opposite the encryption round pipeline and consumes that pipeline's last-round key and ciphertext directly.

---
 rtl/aes_pkg.sv | 109 ++++++++++
 rtl/aes_dec_iter_if.sv | 32 +++
 rtl/inv_key_step.sv | 27 ++
 rtl/aes_dec_iter.sv | 109 ++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES tables, decryptor state type and the byte-level inverse round
// transforms used by the iterative decryption core.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } dec_state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // Indexed directly by the round counter; unused slots are zero.
    localparam logic [7:0] RCON [16] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] m);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Byte i lives at [127-8i -: 8]; row = i%4, column = i/4.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            o[127-8*i -: 8] = INV_SBOX[s[127-8*i -: 8]];
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
            o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
            o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
            o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_dec_iter_if.sv
// Ciphertext-in / plaintext-out handshake bundle for aes_dec_iter.
// key0_out is present only when AES_DEC_KEY_OUT_EN is defined.
interface aes_dec_iter_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] ct_in;
    logic [127:0] last_key_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] pt_out;
`ifdef AES_DEC_KEY_OUT_EN
    logic [127:0] key0_out;

    modport master (
        output in_valid, ct_in, last_key_in, out_ready,
        input  in_ready, out_valid, pt_out, key0_out
    );
    modport slave (
        input  in_valid, ct_in, last_key_in, out_ready,
        output in_ready, out_valid, pt_out, key0_out
    );
`else
    modport master (
        output in_valid, ct_in, last_key_in, out_ready,
        input  in_ready, out_valid, pt_out
    );
    modport slave (
        input  in_valid, ct_in, last_key_in, out_ready,
        output in_ready, out_valid, pt_out
    );
`endif
endinterface

// File: rtl/inv_key_step.sv
// Reverse AES-128 key schedule step: derives round key r-1 from round key r.
module inv_key_step
    import aes_pkg::*;
(
    input  logic [127:0] key_i,
    input  logic [7:0]   rcon_i,
    output logic [127:0] key_o
);
    logic [31:0] w4, w5, w6, w7;
    logic [31:0] w0_p, w1_p, w2_p, w3_p;
    logic [31:0] rot;
    logic [31:0] sub;

    always_comb begin
        w4   = key_i[127:96];
        w5   = key_i[95:64];
        w6   = key_i[63:32];
        w7   = key_i[31:0];
        w3_p = w7 ^ w6;
        w2_p = w6 ^ w5;
        w1_p = w5 ^ w4;
        rot  = {w3_p[23:0], w3_p[31:24]};
        sub  = {SBOX[rot[31:24]], SBOX[rot[23:16]], SBOX[rot[15:8]], SBOX[rot[7:0]]};
        w0_p = w4 ^ sub ^ {rcon_i, 24'h000000};
        key_o = {w0_p, w1_p, w2_p, w3_p};
    end
endmodule

// File: rtl/aes_dec_iter.sv
// Iterative AES-128 decryptor: one inverse round per clock, key schedule run backwards.
// Define AES_DEC_KEY_OUT_EN to also expose the recovered cipher key on key0_out.
module aes_dec_iter
    import aes_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    aes_dec_iter_if.slave  dif
);
    dec_state_t   fsm_q, fsm_d;
    logic [127:0] blk_q, blk_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   rnd_q, rnd_d;
    logic         in_ready_q, in_ready_d;
    logic         out_valid_q, out_valid_d;
    logic [127:0] kp;
    logic [127:0] t;
`ifdef AES_DEC_KEY_OUT_EN
    logic [127:0] key0_q, key0_d;
`endif

    inv_key_step u_inv_key_step (
        .key_i  (key_q),
        .rcon_i (RCON[rnd_q]),
        .key_o  (kp)
    );

    always_comb begin
        fsm_d       = fsm_q;
        blk_d       = blk_q;
        key_d       = key_q;
        rnd_d       = rnd_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
`ifdef AES_DEC_KEY_OUT_EN
        key0_d      = key0_q;
`endif
        t = inv_sub_bytes(inv_shift_rows(blk_q)) ^ kp;
        case (fsm_q)
            IDLE: begin
                if (dif.in_valid && in_ready_q) begin
                    blk_d      = dif.ct_in ^ dif.last_key_in;
                    key_d      = dif.last_key_in;
                    rnd_d      = 4'd10;
                    in_ready_d = 1'b0;
                    fsm_d      = RUN;
                end
            end
            RUN: begin
                key_d = kp;
                rnd_d = rnd_q - 4'd1;
                // Final round skips InvMixColumns and exits exactly at rnd == 1.
                if (rnd_q == 4'd1) begin
                    blk_d       = t;
                    out_valid_d = 1'b1;
                    fsm_d       = DONE;
`ifdef AES_DEC_KEY_OUT_EN
                    key0_d      = kp;
`endif
                end else begin
                    blk_d = inv_mix_columns(t);
                end
            end
            DONE: begin
                if (dif.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    fsm_d       = IDLE;
                end
            end
            default: begin
                fsm_d       = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q       <= IDLE;
            blk_q       <= '0;
            key_q       <= '0;
            rnd_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef AES_DEC_KEY_OUT_EN
            key0_q      <= '0;
`endif
        end else begin
            fsm_q       <= fsm_d;
            blk_q       <= blk_d;
            key_q       <= key_d;
            rnd_q       <= rnd_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef AES_DEC_KEY_OUT_EN
            key0_q      <= key0_d;
`endif
        end
    end

    assign dif.in_ready  = in_ready_q;
    assign dif.out_valid = out_valid_q;
    assign dif.pt_out    = blk_q;
`ifdef AES_DEC_KEY_OUT_EN
    assign dif.key0_out  = key0_q;
`endif
endmodule
